bitstream_decoder: RTL and testbench

Converts a unipolar stochastic bitstream back into a binary value by counting ones over a fixed window of valid samples. It is the decode end of the bitstream path: the weight generators encode binary values as bitstreams, and this block recovers a binary value from a neuron or layer output. Typical use is reading network outputs into a register interface, or feeding a later binary-domain stage. The result is delivered through a valid/ready handshake.

---
 rtl/bitstream_decoder.sv | 202 ++++++++++++++++++++
 tb/tb_bitstream_decoder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bitstream_decoder.sv
// -----------------------------------------------------------------------------
// bitstream_decoder
//
// Recovers a binary value from a unipolar stochastic bitstream by counting the
// ones seen over a window of 2^WINDOW_BITS valid samples. The result is
// offered on a valid/ready handshake.
//
// Build option:
//   DECODER_CONTINUOUS_EN  When defined, the block counts windows back to back
//                          without a start pulse. A result that is still
//                          unaccepted when the next one lands is overwritten,
//                          and the sticky overrun flag is set. When undefined,
//                          each window is launched by start and its result is
//                          held until accepted. In this mode overrun is always 0.
//
// Parameters:
//   WINDOW_BITS   log2 of the window length; also the width of value_out.
//
// Ports:
//   clk           system clock, rising edge
//   n_rst         asynchronous active-low reset
//   start         launch one window (ignored in continuous mode)
//   bit_in        stochastic bitstream sample
//   bit_valid     bit_in is counted only when high
//   value_out     decoded value, saturated to 2^WINDOW_BITS-1
//   value_valid   value_out is available
//   value_ready   consumer accepts value_out
//   busy          a window is being counted
//   overrun       sticky: a result was overwritten before being accepted
// -----------------------------------------------------------------------------
module bitstream_decoder #(
  parameter int WINDOW_BITS = 8
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   start,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  output logic [WINDOW_BITS-1:0] value_out,
  output logic                   value_valid,
  input  logic                   value_ready,
  output logic                   busy,
  output logic                   overrun
);

  // Continuous mode only ever uses the COUNT state.
`ifdef DECODER_CONTINUOUS_EN
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_RESET = S_COUNT;
`else
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_RESET = S_IDLE;
`endif

  // Index of the last sample in a window. The sample counter is exactly
  // WINDOW_BITS wide, so it wraps back to zero on the window-end edge.
  localparam logic [WINDOW_BITS-1:0] LAST_SAMPLE = '1;

  logic [1:0]             state_q;
  logic [1:0]             state_d;
  logic [WINDOW_BITS:0]   ones_q;
  logic [WINDOW_BITS:0]   ones_d;
  logic [WINDOW_BITS-1:0] samples_q;
  logic [WINDOW_BITS-1:0] samples_d;
  logic [WINDOW_BITS-1:0] value_d;
  logic                   valid_d;
  logic                   busy_d;
  logic                   overrun_d;

  // The ones counter carries one extra bit so a full window of ones
  // (2^WINDOW_BITS) is representable before saturation.
  logic [WINDOW_BITS:0]   ones_inc;
  logic [WINDOW_BITS-1:0] value_sat;
  logic                   window_end;

  assign ones_inc   = ones_q + {{WINDOW_BITS{1'b0}}, bit_in};
  assign value_sat  = ones_inc[WINDOW_BITS] ? '1 : ones_inc[WINDOW_BITS-1:0];
  assign window_end = (state_q == S_COUNT) && bit_valid && (samples_q == LAST_SAMPLE);

`ifdef DECODER_CONTINUOUS_EN
  // start has no function when windows run back to back.
  logic unused_start;
  assign unused_start = start;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a hold-current-value default up front so no
    // branch below can leave one unassigned and infer a latch.
    state_d   = state_q;
    ones_d    = ones_q;
    samples_d = samples_q;
    value_d   = value_out;
    valid_d   = value_valid;
    busy_d    = busy;
    overrun_d = overrun;

`ifdef DECODER_CONTINUOUS_EN
    state_d = S_COUNT;
    busy_d  = 1'b1;

    if (bit_valid) begin
      samples_d = samples_q + 1'b1;
      ones_d    = ones_inc;
    end

    if (window_end) begin
      // Restart the ones count on the same edge. The sample counter wraps on
      // its own. A simultaneous ready means the old value was taken on this
      // edge, so replacing it is not a loss.
      ones_d  = '0;
      value_d = value_sat;
      valid_d = 1'b1;
      if (value_valid && !value_ready) begin
        overrun_d = 1'b1;
      end
    end else if (value_ready) begin
      valid_d = 1'b0;
    end
`else
    overrun_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ones_d    = '0;
          samples_d = '0;
          state_d   = S_COUNT;
          busy_d    = 1'b1;
        end
      end

      S_COUNT: begin
        if (bit_valid) begin
          samples_d = samples_q + 1'b1;
          ones_d    = ones_inc;
          if (window_end) begin
            value_d = value_sat;
            valid_d = 1'b1;
            state_d = S_HOLD;
            busy_d  = 1'b0;
          end
        end
      end

      S_HOLD: begin
        if (value_ready) begin
          valid_d = 1'b0;
          // Accept and relaunch on the same edge so back-to-back windows
          // lose no cycle.
          if (start) begin
            ones_d    = '0;
            samples_d = '0;
            state_d   = S_COUNT;
            busy_d    = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
`endif
  end

  // ---------------------------------------------------------------------------
  // State registers. Every output is driven straight from a flop.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      // NOTE: reset clears every register, the counters included. A window
      // cut short by reset must not leak partial counts into the next one.
      state_q     <= S_RESET;
      ones_q      <= '0;
      samples_q   <= '0;
      value_out   <= '0;
      value_valid <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from the same
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      ones_q      <= ones_d;
      samples_q   <= samples_d;
      value_out   <= value_d;
      value_valid <= valid_d;
      busy        <= busy_d;
      overrun     <= overrun_d;
    end
  end

endmodule

// File: tb/tb_bitstream_decoder.sv
// -----------------------------------------------------------------------------
// tb_bitstream_decoder
//
// Self-checking bench for bitstream_decoder with WINDOW_BITS=4. Expected
// results come from a reference model. The model counts the ones in each
// 16-sample window with plain arithmetic and saturates the count to 15. Inputs
// change and outputs are read 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_bitstream_decoder;

  localparam int WB     = 4;
  localparam int WINDOW = 1 << WB;
  localparam int MAXV   = WINDOW - 1;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start;
  logic          bit_in;
  logic          bit_valid;
  logic [WB-1:0] value_out;
  logic          value_valid;
  logic          value_ready;
  logic          busy;
  logic          overrun;

  int n_tests = 0;
  int n_fail  = 0;

  bitstream_decoder #(.WINDOW_BITS(WB)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .value_out   (value_out),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the decoded value of a window is its ones count,
  // saturated to the output width.
  function automatic int model_value(input logic [WINDOW-1:0] bits);
    int ones = 0;
    for (int i = 0; i < WINDOW; i++) ones += int'(bits[i]);
    return (ones > MAXV) ? MAXV : ones;
  endfunction

  // Feeds one full window of samples. gap_mode selects when bit_valid is low:
  // 0 = never, 1 = every other cycle starting low, 2 = random. Invalid cycles
  // carry random bit_in, which must be ignored. In handshake mode, start and
  // value_ready are randomised while counting, since both must be ignored.
  // The window end is checked against the model.
  task automatic feed_window(input string tag, input logic [WINDOW-1:0] bits,
                             input int gap_mode, input bit cont, output int cycles);
    int idx = 0;
    bit v;
    bit early = 1'b0;
    int exp_v = model_value(bits);
    cycles = 0;
    while (idx < WINDOW && cycles < 400) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cycles % 2) == 1;
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      bit_valid   = v;
      bit_in      = v ? bits[idx] : 1'($urandom_range(0, 1));
      value_ready = cont ? 1'b0 : 1'($urandom_range(0, 1));
      start       = cont ? 1'b0 : 1'($urandom_range(0, 1));
      tick();
      cycles++;
      if (v) idx++;
      if (!cont && idx < WINDOW && (value_valid || !busy)) early = 1'b1;
    end
    bit_valid   = 1'b0;
    bit_in      = 1'b0;
    value_ready = 1'b0;
    start       = 1'b0;
    check({tag, ":window_complete"}, idx, WINDOW);
    check({tag, ":no_early_result"}, early, 0);
    check({tag, ":value"}, value_out, exp_v);
    check({tag, ":valid"}, value_valid, 1);
    check({tag, ":busy"}, busy, cont ? 1 : 0);
  endtask

`ifndef DECODER_CONTINUOUS_EN
  task automatic launch(input string tag);
    start     = 1'b1;
    bit_valid = 1'($urandom_range(0, 1));
    bit_in    = 1'($urandom_range(0, 1));
    tick();
    start = 1'b0;
    check({tag, ":busy_after_start"}, busy, 1);
    check({tag, ":valid_after_start"}, value_valid, 0);
  endtask

  task automatic accept(input string tag);
    value_ready = 1'b1;
    start       = 1'b0;
    tick();
    value_ready = 1'b0;
    check({tag, ":valid_after_accept"}, value_valid, 0);
    check({tag, ":busy_after_accept"}, busy, 0);
  endtask
`endif

  initial begin
    int cyc;
    logic [WINDOW-1:0] pat;
    logic [WB-1:0] held;
    bit unstable;

    n_rst = 1'b0; start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; value_ready = 1'b0;
    tick();
    tick();
    check("reset:value_out", value_out, 0);
    check("reset:value_valid", value_valid, 0);
    check("reset:busy", busy, 0);
    check("reset:overrun", overrun, 0);
    n_rst = 1'b1;

`ifdef DECODER_CONTINUOUS_EN
    // Two windows with no consumer: the second result replaces the first and
    // raises overrun.
    pat = WINDOW'($urandom_range(0, 65535));
    feed_window("cont_w1", pat, 2, 1'b1, cyc);
    check("cont_w1:overrun", overrun, 0);
    pat = WINDOW'($urandom_range(0, 65535));
    feed_window("cont_w2", pat, 2, 1'b1, cyc);
    check("cont_w2:overrun", overrun, 1);
    value_ready = 1'b1;
    tick();
    value_ready = 1'b0;
    check("cont_accept:valid", value_valid, 0);
    check("cont_accept:overrun_sticky", overrun, 1);
    check("cont_accept:busy", busy, 1);
    pat = '1;
    feed_window("cont_w3_sat", pat, 0, 1'b1, cyc);
    check("cont_w3:cycles", cyc, WINDOW);
    check("cont_w3:overrun_sticky", overrun, 1);
`else
    // All ones with no gaps: saturates, and the result appears 16 edges after
    // start.
    launch("ones");
    feed_window("ones", '1, 0, 1'b0, cyc);
    check("ones:latency", cyc, WINDOW);
    accept("ones");

    launch("alt");
    feed_window("alt", 16'h5555, 0, 1'b0, cyc);
    accept("alt");

    launch("zeros");
    feed_window("zeros", '0, 0, 1'b0, cyc);
    accept("zeros");

    // Exactly 15 ones: the largest value that needs no saturation.
    launch("fifteen");
    feed_window("fifteen", 16'h7FFF, 2, 1'b0, cyc);
    accept("fifteen");

    // bit_valid low on every other cycle: 32 cycles for 16 samples.
    launch("gaps");
    feed_window("gaps", 16'h00FF, 1, 1'b0, cyc);
    check("gaps:latency", cyc, 2 * WINDOW);

    // The result must hold through 20 cycles without ready, with start and
    // samples toggling.
    held = value_out;
    unstable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      start     = 1'($urandom_range(0, 1));
      bit_valid = 1'($urandom_range(0, 1));
      bit_in    = 1'($urandom_range(0, 1));
      tick();
      if (value_out !== held || value_valid !== 1'b1 || busy !== 1'b0) unstable = 1'b1;
    end
    check("hold:stable", unstable, 0);

    // Ready together with start relaunches on the same edge.
    value_ready = 1'b1;
    start       = 1'b1;
    bit_valid   = 1'b0;
    tick();
    value_ready = 1'b0;
    start       = 1'b0;
    check("b2b:valid_drop", value_valid, 0);
    check("b2b:busy", busy, 1);
    pat = WINDOW'($urandom_range(0, 65535));
    feed_window("b2b", pat, 2, 1'b0, cyc);
    accept("b2b");

    for (int w = 0; w < 6; w++) begin
      pat = WINDOW'($urandom_range(0, 65535));
      launch("rand");
      feed_window("rand", pat, 2, 1'b0, cyc);
      accept("rand");
    end

    // A mid-window reset clears everything at once. The preceding all-ones
    // window leaves value_out nonzero, so the clear can be observed.
    launch("pre_rst");
    feed_window("pre_rst", '1, 0, 1'b0, cyc);
    accept("pre_rst");
    launch("mid_rst");
    for (int i = 0; i < 7; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      tick();
    end
    #2 n_rst = 1'b0;
    #1;
    check("mid_rst:value_out", value_out, 0);
    check("mid_rst:value_valid", value_valid, 0);
    check("mid_rst:busy", busy, 0);
    check("mid_rst:overrun", overrun, 0);
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    tick();
    n_rst = 1'b1;
    tick();
    check("post_rst:idle", busy, 0);
    pat = 16'h0F0F;
    launch("fresh");
    feed_window("fresh", pat, 2, 1'b0, cyc);
    accept("fresh");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
